// File: rtl/multicycle_alu_controller.sv
// Moore control FSM for the multi-cycle CPU.
// Sequences IF/ID/EX/MEM/WB and drives ALU, PC, memory and register-file controls.
module multicycle_alu_controller #(
    parameter int STATE_W = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] OpCode,
    input  logic [5:0] Funct,
    output logic       PCWrite,
    output logic       PCWriteCond,
    output logic       IorD,
    output logic       MemRead,
    output logic       MemWrite,
    output logic       IRWrite,
    output logic       RegWrite,
    output logic [1:0] RegDst,
    output logic [1:0] MemtoReg,
    output logic       ExtOp,
    output logic       LuOp,
    output logic [1:0] ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [1:0] PCSource,
    output logic [4:0] ALUConf,
    output logic       Sign,
    output logic       Illegal
);

    localparam logic [STATE_W-1:0] S_IF     = STATE_W'(0);
    localparam logic [STATE_W-1:0] S_ID     = STATE_W'(1);
    localparam logic [STATE_W-1:0] S_EX_R   = STATE_W'(2);
    localparam logic [STATE_W-1:0] S_EX_I   = STATE_W'(3);
    localparam logic [STATE_W-1:0] S_ADDR   = STATE_W'(4);
    localparam logic [STATE_W-1:0] S_MEM_RD = STATE_W'(5);
    localparam logic [STATE_W-1:0] S_MEM_WR = STATE_W'(6);
    localparam logic [STATE_W-1:0] S_WB_MEM = STATE_W'(7);
    localparam logic [STATE_W-1:0] S_WB_ALU = STATE_W'(8);
    localparam logic [STATE_W-1:0] S_BEQ    = STATE_W'(9);
    localparam logic [STATE_W-1:0] S_JUMP   = STATE_W'(10);

    localparam logic [4:0] C_ADD = 5'b00000;
    localparam logic [4:0] C_OR  = 5'b00001;
    localparam logic [4:0] C_AND = 5'b00010;
    localparam logic [4:0] C_SUB = 5'b00110;
    localparam logic [4:0] C_SLT = 5'b00111;
    localparam logic [4:0] C_NOR = 5'b01100;
    localparam logic [4:0] C_XOR = 5'b01101;
    localparam logic [4:0] C_SRL = 5'b10000;
    localparam logic [4:0] C_SRA = 5'b11000;
    localparam logic [4:0] C_SLL = 5'b11001;

    logic [STATE_W-1:0] state;
    logic [STATE_W-1:0] state_nxt;

    logic       is_r, r_ok, is_jr, is_r_alu, is_shift, r_sign;
    logic       is_lw, is_sw, is_imm, is_beq, is_j, is_jal, legal;
    logic [4:0] r_conf, i_conf;

    // Instruction class decode from the IR fields
    always_comb begin
        is_r     = (OpCode == 6'h00);
        r_ok     = 1'b1;
        is_shift = 1'b0;
        r_sign   = 1'b0;
        r_conf   = C_ADD;
        case (Funct)
            6'h00: begin r_conf = C_SLL; is_shift = 1'b1; end
            6'h02: begin r_conf = C_SRL; is_shift = 1'b1; end
            6'h03: begin r_conf = C_SRA; is_shift = 1'b1; end
            6'h08: r_conf = C_ADD;
            6'h20: begin r_conf = C_ADD; r_sign = 1'b1; end
            6'h21: r_conf = C_ADD;
            6'h22: begin r_conf = C_SUB; r_sign = 1'b1; end
            6'h23: r_conf = C_SUB;
            6'h24: r_conf = C_AND;
            6'h25: r_conf = C_OR;
            6'h26: r_conf = C_XOR;
            6'h27: r_conf = C_NOR;
            6'h2a: begin r_conf = C_SLT; r_sign = 1'b1; end
            6'h2b: r_conf = C_SLT;
            default: r_ok = 1'b0;
        endcase
        is_jr    = is_r & (Funct == 6'h08);
        is_r_alu = is_r & r_ok & ~is_jr;
        is_lw    = (OpCode == 6'h23);
        is_sw    = (OpCode == 6'h2b);
        is_beq   = (OpCode == 6'h04);
        is_j     = (OpCode == 6'h02);
        is_jal   = (OpCode == 6'h03);
        is_imm   = 1'b1;
        i_conf   = C_ADD;
        case (OpCode)
            6'h08, 6'h09, 6'h0f: i_conf = C_ADD;
            6'h0a, 6'h0b:        i_conf = C_SLT;
            6'h0c:               i_conf = C_AND;
            6'h0d:               i_conf = C_OR;
            default:             is_imm = 1'b0;
        endcase
        legal = is_jr | is_r_alu | is_lw | is_sw | is_imm
              | is_beq | is_j | is_jal;
    end

    // Next-state sequencing
    always_comb begin
        state_nxt = S_IF;
        case (state)
            S_IF: state_nxt = S_ID;
            S_ID: begin
                unique case (1'b1)
                    is_jr:          state_nxt = S_JUMP;
                    is_r_alu:       state_nxt = S_EX_R;
                    is_lw | is_sw:  state_nxt = S_ADDR;
                    is_imm:         state_nxt = S_EX_I;
                    is_beq:         state_nxt = S_BEQ;
                    is_j | is_jal:  state_nxt = S_JUMP;
                    default:        state_nxt = S_IF;
                endcase
            end
            S_EX_R:   state_nxt = S_WB_ALU;
            S_EX_I:   state_nxt = S_WB_ALU;
            S_ADDR:   state_nxt = is_lw ? S_MEM_RD : S_MEM_WR;
            S_MEM_RD: state_nxt = S_WB_MEM;
            default:  state_nxt = S_IF;
        endcase
    end

    // State register with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!reset) state <= S_IF;
        else        state <= state_nxt;
    end

    // Moore output decode; everything held at 0 while in reset
    always_comb begin
        PCWrite     = 1'b0;
        PCWriteCond = 1'b0;
        IorD        = 1'b0;
        MemRead     = 1'b0;
        MemWrite    = 1'b0;
        IRWrite     = 1'b0;
        RegWrite    = 1'b0;
        RegDst      = 2'b00;
        MemtoReg    = 2'b00;
        ExtOp       = 1'b0;
        LuOp        = 1'b0;
        ALUSrcA     = 2'b00;
        ALUSrcB     = 2'b00;
        PCSource    = 2'b00;
        ALUConf     = C_ADD;
        Sign        = 1'b0;
        Illegal     = 1'b0;
        if (reset) begin
            case (state)
                S_IF: begin
                    MemRead = 1'b1;
                    IRWrite = 1'b1;
                    ALUSrcB = 2'b01;
                    PCWrite = 1'b1;
                end
                S_ID: begin
                    ALUSrcB = 2'b11;
                    ExtOp   = 1'b1;
                    Illegal = ~legal;
                end
                S_EX_R: begin
                    ALUSrcA = is_shift ? 2'b10 : 2'b01;
                    ALUConf = r_conf;
                    Sign    = r_sign;
                end
                S_EX_I: begin
                    ALUSrcA = 2'b01;
                    ALUSrcB = 2'b10;
                    ExtOp   = ~((OpCode == 6'h0c) | (OpCode == 6'h0d));
                    LuOp    = (OpCode == 6'h0f);
                    ALUConf = i_conf;
                    Sign    = (OpCode == 6'h0a);
                end
                S_ADDR: begin
                    ALUSrcA = 2'b01;
                    ALUSrcB = 2'b10;
                    ExtOp   = 1'b1;
                end
                S_MEM_RD: begin
                    MemRead = 1'b1;
                    IorD    = 1'b1;
                end
                S_MEM_WR: begin
                    MemWrite = 1'b1;
                    IorD     = 1'b1;
                end
                S_WB_MEM: begin
                    RegWrite = 1'b1;
                    MemtoReg = 2'b01;
                end
                S_WB_ALU: begin
                    RegWrite = 1'b1;
                    RegDst   = is_r ? 2'b01 : 2'b00;
                end
                S_BEQ: begin
                    ALUSrcA     = 2'b01;
                    ALUConf     = C_SUB;
                    PCWriteCond = 1'b1;
                    PCSource    = 2'b01;
                end
                S_JUMP: begin
                    PCWrite  = 1'b1;
                    PCSource = is_jr ? 2'b11 : 2'b10;
                    if (is_jal) begin
                        RegWrite = 1'b1;
                        RegDst   = 2'b10;
                        MemtoReg = 2'b10;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_multicycle_alu_controller.sv
// Randomized bench for multicycle_alu_controller.
// Expected per-cycle controls come from an instruction-level reference model.
module tb_multicycle_alu_controller;

    typedef struct packed {
        logic       pcw, pcwc, iord, mrd, mwr, irw, rw;
        logic [1:0] rdst, m2r;
        logic       ext, lu;
        logic [1:0] sa, sb, pcs;
        logic [4:0] conf;
        logic       sgn, ill;
    } ctl_t;

    localparam int K_BAD = 0, K_R = 1, K_JR = 2, K_LW = 3, K_SW = 4;
    localparam int K_IMM = 5, K_BEQ = 6, K_J = 7, K_JAL = 8;

    logic       clk = 1'b0;
    logic       reset;
    logic [5:0] OpCode, Funct;
    logic       PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite;
    logic       RegWrite, ExtOp, LuOp, Sign, Illegal;
    logic [1:0] RegDst, MemtoReg, ALUSrcA, ALUSrcB, PCSource;
    logic [4:0] ALUConf;

    ctl_t obs;
    ctl_t exp_c [5];
    int   exp_n;
    int   n_chk  = 0;
    int   n_pass = 0;

    multicycle_alu_controller dut (
        .clk(clk), .reset(reset), .OpCode(OpCode), .Funct(Funct),
        .PCWrite(PCWrite), .PCWriteCond(PCWriteCond), .IorD(IorD),
        .MemRead(MemRead), .MemWrite(MemWrite), .IRWrite(IRWrite),
        .RegWrite(RegWrite), .RegDst(RegDst), .MemtoReg(MemtoReg),
        .ExtOp(ExtOp), .LuOp(LuOp), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB),
        .PCSource(PCSource), .ALUConf(ALUConf), .Sign(Sign),
        .Illegal(Illegal)
    );

    always #5 clk = ~clk;

    always_comb obs = {PCWrite, PCWriteCond, IorD, MemRead, MemWrite,
                       IRWrite, RegWrite, RegDst, MemtoReg, ExtOp, LuOp,
                       ALUSrcA, ALUSrcB, PCSource, ALUConf, Sign, Illegal};

    task automatic check(input string tag, input ctl_t got, input ctl_t want);
        n_chk++;
        if (got === want) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, want);
    endtask

    // Reference: the per-cycle control list for one whole instruction
    task automatic build(input logic [5:0] op, input logic [5:0] fn);
        ctl_t c;
        int   kind;
        kind = K_BAD;
        if (op == 6'h00) begin
            if (fn == 6'h08) kind = K_JR;
            else if (fn inside {6'h00, 6'h02, 6'h03, 6'h20, 6'h21, 6'h22,
                                6'h23, 6'h24, 6'h25, 6'h26, 6'h27,
                                6'h2a, 6'h2b}) kind = K_R;
        end else begin
            case (op)
                6'h23: kind = K_LW;
                6'h2b: kind = K_SW;
                6'h08, 6'h09, 6'h0a, 6'h0b,
                6'h0c, 6'h0d, 6'h0f: kind = K_IMM;
                6'h04: kind = K_BEQ;
                6'h02: kind = K_J;
                6'h03: kind = K_JAL;
                default: kind = K_BAD;
            endcase
        end
        c = '0; c.pcw = 1; c.mrd = 1; c.irw = 1; c.sb = 2'b01;
        exp_c[0] = c;
        c = '0; c.sb = 2'b11; c.ext = 1; c.ill = (kind == K_BAD);
        exp_c[1] = c;
        exp_n = 2;
        case (kind)
            K_R: begin
                c = '0;
                c.sa = (fn inside {6'h00, 6'h02, 6'h03}) ? 2'b10 : 2'b01;
                case (fn)
                    6'h00: c.conf = 5'b11001;
                    6'h02: c.conf = 5'b10000;
                    6'h03: c.conf = 5'b11000;
                    6'h22, 6'h23: c.conf = 5'b00110;
                    6'h24: c.conf = 5'b00010;
                    6'h25: c.conf = 5'b00001;
                    6'h26: c.conf = 5'b01101;
                    6'h27: c.conf = 5'b01100;
                    6'h2a, 6'h2b: c.conf = 5'b00111;
                    default: c.conf = 5'b00000;
                endcase
                c.sgn = (fn inside {6'h20, 6'h22, 6'h2a});
                exp_c[2] = c;
                c = '0; c.rw = 1; c.rdst = 2'b01;
                exp_c[3] = c;
                exp_n = 4;
            end
            K_IMM: begin
                c = '0; c.sa = 2'b01; c.sb = 2'b10;
                c.ext = !(op inside {6'h0c, 6'h0d});
                c.lu  = (op == 6'h0f);
                case (op)
                    6'h0a, 6'h0b: c.conf = 5'b00111;
                    6'h0c: c.conf = 5'b00010;
                    6'h0d: c.conf = 5'b00001;
                    default: c.conf = 5'b00000;
                endcase
                c.sgn = (op == 6'h0a);
                exp_c[2] = c;
                c = '0; c.rw = 1;
                exp_c[3] = c;
                exp_n = 4;
            end
            K_LW, K_SW: begin
                c = '0; c.sa = 2'b01; c.sb = 2'b10; c.ext = 1;
                exp_c[2] = c;
                c = '0; c.iord = 1;
                if (kind == K_LW) c.mrd = 1; else c.mwr = 1;
                exp_c[3] = c;
                exp_n = 4;
                if (kind == K_LW) begin
                    c = '0; c.rw = 1; c.m2r = 2'b01;
                    exp_c[4] = c;
                    exp_n = 5;
                end
            end
            K_BEQ: begin
                c = '0; c.sa = 2'b01; c.conf = 5'b00110;
                c.pcwc = 1; c.pcs = 2'b01;
                exp_c[2] = c;
                exp_n = 3;
            end
            K_J, K_JAL, K_JR: begin
                c = '0; c.pcw = 1;
                c.pcs = (kind == K_JR) ? 2'b11 : 2'b10;
                if (kind == K_JAL) begin
                    c.rw = 1; c.rdst = 2'b10; c.m2r = 2'b10;
                end
                exp_c[2] = c;
                exp_n = 3;
            end
            default: ;
        endcase
    endtask

    // Starts just after the edge that begins IF; ends just after the next IF edge
    task automatic run_instr(input logic [5:0] op, input logic [5:0] fn);
        OpCode = op;
        Funct  = fn;
        build(op, fn);
        for (int k = 0; k < exp_n; k++) begin
            @(negedge clk);
            check($sformatf("op%02h/fn%02h cyc%0d", op, fn, k), obs, exp_c[k]);
            @(posedge clk);
            #1;
        end
    endtask

    // sw interrupted by reset in its MEM_WR cycle
    task automatic run_sw_reset();
        OpCode = 6'h2b;
        Funct  = 6'h00;
        build(6'h2b, 6'h00);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check($sformatf("swrst cyc%0d", k), obs, exp_c[k]);
            @(posedge clk);
            #1;
        end
        reset = 1'b0;
        @(negedge clk);
        check("swrst memwr_in_reset", obs, '0);
        @(posedge clk);
        #1;
        reset = 1'b1;
    endtask

    logic [5:0] r_fns [14] = '{6'h00, 6'h02, 6'h03, 6'h08, 6'h20, 6'h21,
                               6'h22, 6'h23, 6'h24, 6'h25, 6'h26, 6'h27,
                               6'h2a, 6'h2b};
    logic [5:0] ops [12] = '{6'h23, 6'h2b, 6'h08, 6'h09, 6'h0a, 6'h0b,
                             6'h0c, 6'h0d, 6'h0f, 6'h04, 6'h02, 6'h03};

    initial begin
        int r;
        reset  = 1'b0;
        OpCode = 6'h00;
        Funct  = 6'h00;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            OpCode = 6'($urandom);
            Funct  = 6'($urandom);
            @(negedge clk);
            check($sformatf("in_reset%0d", i), obs, '0);
        end
        @(posedge clk);
        #1;
        reset = 1'b1;

        run_instr(6'h00, 6'h22);
        run_instr(6'h00, 6'h03);
        run_instr(6'h00, 6'h2b);
        run_instr(6'h23, 6'h00);
        run_instr(6'h2b, 6'h00);
        run_instr(6'h04, 6'h00);
        run_instr(6'h03, 6'h00);
        run_instr(6'h3f, 6'h00);
        run_instr(6'h00, 6'h08);
        run_instr(6'h0f, 6'h11);
        run_sw_reset();
        run_instr(6'h00, 6'h24);

        for (int i = 0; i < 250; i++) begin
            r = int'($urandom_range(0, 9));
            if (r < 2)
                run_instr(6'($urandom), 6'($urandom));
            else if (r < 5)
                run_instr(6'h00, r_fns[$urandom_range(0, 13)]);
            else
                run_instr(ops[$urandom_range(0, 11)], 6'($urandom));
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, %0d/%0d", n_pass, n_chk);
        $fatal(1);
    end

endmodule
